adder_result_display: RTL and testbench
=======================================

# adder_result_display

Downstream consumer of the n-bit ripple adder in the DE-series adder demo. It captures the adder's sum and carry-out on a load strobe and converts the (N+1)-bit result to BCD with a sequential shift-add-3 (double-dabble) engine. It then drives the decimal value onto the board's active-low seven-segment displays. It turns the raw LED result into a human-readable decimal readout.

## Interface
Parameters:
- N, 4, adder operand width; the captured value is {cout, sum}, N+1 bits.
- DIGITS, 2, number of BCD digits/HEX displays driven; must satisfy 10^DIGITS > 2^(N+1)-1.

Ports:
- Clock  input  1  system clock (CLOCK_50 at top level).
- Resetn  input  1  reset; one clock, reset is synchronous and active-low.
- load  input  1  single-cycle strobe requesting capture of the current adder result.
- sum  input  N  adder sum output.
- cout  input  1  adder carry-out.
- busy  output  1  high while a conversion is in progress.
- done  output  1  single-cycle pulse when the display registers update.
- HEX  output  7*DIGITS  seven-segment drive, active-low, digit k on HEX[7k+6:7k], bit0=a … bit6=g.

## Operation
- FSM states: IDLE, CONVERT, COMMIT.
- IDLE:
  - On load=1, register value={cout,sum}, clear the BCD shift register, clear the iteration counter, and go to CONVERT.
  - With load=0, stay in IDLE.
- CONVERT, one iteration per cycle:
  - Each BCD nibble ≥5 gets +3.
  - Then shift the {bcd, value} concatenation left by 1.
  - Increment the counter.
  - After exactly N+1 iterations, go to COMMIT.
- COMMIT:
  - Copy the BCD digits into the display registers.
  - Pulse done for one cycle.
  - Return to IDLE.
- Display encoding:
  - Digits 0–9 use standard active-low patterns: 0=7'b1000000, 1=7'b1111001, 2=7'b0100100, 3=7'b0110000, 4=7'b0011001, 5=7'b0010010, 6=7'b0000010, 7=7'b1111000, 8=7'b0000000, 9=7'b0010000.
  - Leading-zero blanking: digit k>0 is blanked (7'h7F) if it and all higher digits are 0. Digit 0 is never blanked after the first commit.
- load while busy=1 (CONVERT or COMMIT) is ignored and dropped. The display keeps its previous value until the in-flight conversion commits.
- sum/cout are sampled only in the load cycle. Later changes have no effect on an in-flight conversion.
- Width rules:
  - The BCD register is 4*DIGITS bits and the counter is clog2(N+2) bits.
  - No overflow is possible given the DIGITS constraint.

## Timing
- Reset:
  - Resetn=0 at a rising edge forces IDLE, busy=0, done=0, and HEX all 1s (all segments off).
  - It also clears the internal registers.
  - Reset has priority over load in the same cycle.
  - Reset during CONVERT aborts the conversion with no commit.
- Latency:
  - load sampled at edge t.
  - busy=1 from t+1 through t+N+2 (N+1 CONVERT cycles plus COMMIT).
  - done=1 and new HEX valid from edge t+N+2; busy=0 from t+N+3.
- Throughput: one conversion per N+3 cycles. load in the cycle busy falls (IDLE) is accepted.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package (adder_display_pkg):
  - state enum {IDLE, CONVERT, COMMIT}.
  - SEG_BLANK=7'h7F.
  - The ten digit segment constants.
- Sub-module seg7_decoder (4-bit BCD → 7-bit active-low pattern, combinational). It is instantiated DIGITS times, feeding registered outputs.
- At top level, instantiation sits beside the adder: load comes from a KEY[0] edge detector, sum from LEDR[3:0], cout from LEDR[4], and HEX maps to {HEX1,HEX0}.

## Test plan
- Reset: hold Resetn=0 for 3 cycles → HEX=14'h3FFF, busy=0, done=0.
- N=4, sum=4'hF, cout=1 (31), pulse load → busy high for 6 cycles; done at cycle 6; HEX1="3" 7'b0110000, HEX0="1" 7'b1111001.
- sum=4'h7, cout=0 (7) → HEX1 blank 7'h7F, HEX0=7'b1111000. sum=0, cout=0 → HEX1 blank, HEX0="0".
- load pulses at 2 and 4 cycles after a first load with different sum → only the first value is displayed and only one done pulse occurs. A load on the cycle after busy falls is accepted.
- Reset asserted mid-CONVERT (cycle 3) → no done, HEX blank, FSM in IDLE; the next load converts correctly.
- Exhaustive sweep of all 32 {cout,sum} values with back-to-back loads → every display matches the decimal reference model.

Source files
------------

// File: rtl/adder_display_pkg.sv
// Shared types and seven-segment constants for the adder result display.
// Segment patterns are active-low, bit0 = a ... bit6 = g.
package adder_display_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CONVERT,
      COMMIT
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to active-low seven-segment pattern; non-decimal codes show blank.
module seg7_decoder
   import adder_display_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/adder_result_display.sv
// Captures {cout,sum} on load, converts to BCD by sequential double-dabble and
// drives leading-zero-blanked active-low seven-segment displays.
module adder_result_display
   import adder_display_pkg::*;
#(
   parameter int N      = 4,
   parameter int DIGITS = 2
) (
   input  logic                  Clock,
   input  logic                  Resetn,
   input  logic                  load,
   input  logic [N-1:0]          sum,
   input  logic                  cout,
   output logic                  busy,
   output logic                  done,
   output logic [7*DIGITS-1:0]   HEX
);

   localparam int CW = $clog2(N + 2);
   localparam int BW = 4 * DIGITS;

   state_t            state, next_state;
   logic [N:0]        value, value_nxt;
   logic [BW-1:0]     bcd, bcd_adj, bcd_nxt;
   logic [CW-1:0]     cnt;
   logic              last_iter;
   logic              busy_d, done_d, commit;
   logic [7*DIGITS-1:0] seg_raw, hex_nxt;
   logic              all_zero;

   assign last_iter = (cnt == CW'(N));

   // One double-dabble iteration: add 3 to any nibble >= 5, then shift left.
   always_comb begin
      bcd_adj = bcd;
      for (int unsigned d = 0; d < DIGITS; d++) begin
         if (bcd[4*d +: 4] >= 4'd5)
            bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
      end
      {bcd_nxt, value_nxt} = {bcd_adj, value} << 1;
   end

   for (genvar k = 0; k < DIGITS; k++) begin : g_dec
      seg7_decoder u_dec (
         .bcd (bcd_nxt[4*k +: 4]),
         .seg (seg_raw[7*k +: 7])
      );
   end

   always_comb begin
      hex_nxt  = seg_raw;
      all_zero = 1'b1;
      for (int unsigned k = DIGITS - 1; k >= 1; k--) begin
         all_zero = all_zero && (bcd_nxt[4*k +: 4] == 4'd0);
         if (all_zero)
            hex_nxt[7*k +: 7] = SEG_BLANK;
      end
   end

   always_ff @(posedge Clock) begin
      if (!Resetn)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (load) next_state = CONVERT;
         CONVERT: if (last_iter) next_state = COMMIT;
         COMMIT:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Display and done are loaded on the final iteration edge straight from the
   // next-BCD value, so they are valid for the whole COMMIT cycle.
   always_comb begin
      busy_d = (next_state != IDLE);
      done_d = (next_state == COMMIT);
      commit = (state == CONVERT) && last_iter;
   end

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         value <= '0;
         bcd   <= '0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         HEX   <= '1;
      end else begin
         busy <= busy_d;
         done <= done_d;
         if (state == IDLE && load) begin
            value <= {cout, sum};
            bcd   <= '0;
            cnt   <= '0;
         end else if (state == CONVERT) begin
            value <= value_nxt;
            bcd   <= bcd_nxt;
            cnt   <= cnt + CW'(1);
         end
         if (commit)
            HEX <= hex_nxt;
      end
   end

endmodule

// File: tb/tb_adder_result_display.sv
// Directed bench for adder_result_display (N=4, DIGITS=2) with a decimal
// reference model for the expected display.
module tb_adder_result_display;

   logic        Clock = 1'b0;
   logic        Resetn;
   logic        load;
   logic [3:0]  sum;
   logic        cout;
   logic        busy;
   logic        done;
   logic [13:0] HEX;

   int checks = 0;
   int errors = 0;
   int dones;

   adder_result_display #(.N(4), .DIGITS(2)) dut (
      .Clock  (Clock),
      .Resetn (Resetn),
      .load   (load),
      .sum    (sum),
      .cout   (cout),
      .busy   (busy),
      .done   (done),
      .HEX    (HEX)
   );

   always #5 Clock = ~Clock;

   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'h7F;
      endcase
   endfunction

   function automatic logic [13:0] exp_hex(input int v);
      int tens, ones;
      tens = v / 10;
      ones = v % 10;
      return {(tens == 0) ? 7'h7F : seg_of(tens), seg_of(ones)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   // Loads v, then checks the busy/done profile and final display.
   task automatic convert(input int v);
      logic [4:0] vb;
      vb   = 5'(v);
      sum  = vb[3:0];
      cout = vb[4];
      load = 1'b1;
      tick();
      load = 1'b0;
      sum  = ~sum;
      cout = ~cout;
      for (int i = 1; i <= 6; i++) begin
         chk("conv_busy", busy, 1);
         chk("conv_done", done, (i == 6));
         if (i == 6) chk("conv_hex", HEX, exp_hex(v));
         tick();
      end
      chk("conv_busy_fall", busy, 0);
      chk("conv_done_fall", done, 0);
   endtask

   initial begin
      Resetn = 1'b0;
      load   = 1'b0;
      sum    = 4'h0;
      cout   = 1'b0;
      tick(); tick(); tick();
      chk("rst_hex", HEX, 14'h3FFF);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      Resetn = 1'b1;
      tick();
      chk("idle_busy", busy, 0);

      convert(31);
      chk("hex31_direct", HEX, {7'b0110000, 7'b1111001});
      convert(7);
      chk("hex7_direct", HEX, {7'h7F, 7'b1111000});
      convert(0);
      chk("hex0_direct", HEX, {7'h7F, 7'b1000000});

      // Loads during a conversion are dropped.
      sum  = 4'h9;
      cout = 1'b0;
      load = 1'b1;
      tick();
      dones = 0;
      for (int i = 1; i <= 10; i++) begin
         dones += int'(done);
         load = (i == 2 || i == 4);
         sum  = 4'h3;
         tick();
      end
      load = 1'b0;
      chk("drop_dones", dones, 1);
      chk("drop_hex", HEX, {7'h7F, 7'b0010000});
      chk("drop_busy", busy, 0);

      // Reset in the middle of a conversion aborts it.
      sum  = 4'h5;
      cout = 1'b1;
      load = 1'b1;
      tick();
      load = 1'b0;
      tick(); tick();
      Resetn = 1'b0;
      tick();
      Resetn = 1'b1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_hex", HEX, 14'h3FFF);
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         dones += int'(done);
         tick();
      end
      chk("abort_no_done", dones, 0);
      chk("abort_hex_hold", HEX, 14'h3FFF);
      convert(22);

      for (int v = 0; v < 32; v++)
         convert(v);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
